// File: rtl/knight_pkg.sv
// Shared constants and types for the KnightsTour command link:
// protocol bytes, opcodes, headings, and the UART/assembler state encodings.
package knight_pkg;

    localparam int BAUD_DIV_DEFAULT = 2604;

    localparam logic [7:0]  POS_ACK      = 8'hA5;
    localparam logic [15:0] CAL_GYRO     = 16'h2000;
    localparam logic [3:0]  MOVE         = 4'h4;
    localparam logic [3:0]  MOVE_FANFARE = 4'h5;

    localparam logic [7:0] NORTH = 8'h00;
    localparam logic [7:0] EAST  = 8'hBF;
    localparam logic [7:0] SOUTH = 8'h7F;
    localparam logic [7:0] WEST  = 8'h3F;

    typedef enum logic {HIGH, LOW} asm_state_t;
    typedef enum logic {RX_IDLE, RX_RECV} rx_state_t;

    // Serial frame as shifted out LSB first: start bit, data, stop bit.
    function automatic logic [9:0] tx_frame(input logic [7:0] data);
        return {1'b1, data, 1'b0};
    endfunction

endpackage

// File: rtl/uart_wrapper_if.sv
// Pin- and command-side signals of the RemoteComm responder.
// slave = the wrapper, master = the host/consumer side driving it.
interface uart_wrapper_if;
    logic        RX;
    logic        TX;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic [7:0]  resp;
    logic        trmt;
    logic        tx_done;

    modport slave (
        input  RX, clr_cmd_rdy, resp, trmt,
        output TX, cmd, cmd_rdy, tx_done
    );

    modport master (
        output RX, clr_cmd_rdy, resp, trmt,
        input  TX, cmd, cmd_rdy, tx_done
    );
endinterface

// File: rtl/uart_wrapper_uart.sv
// Full-duplex 8N1 byte UART; RX and TX run independently off one clock.
// Shared with RemoteComm on the host side.
module uart
    import knight_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    output logic       TX,
    output logic       rx_rdy,
    input  logic       clr_rx_rdy,
    output logic [7:0] rx_data,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       tx_done
);

    localparam int CW = $clog2(BAUD_DIV + 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_LOAD = CW'(BAUD_DIV / 2 - 1);

    logic            r_rx_ff1, r_rx_ff2, r_rx_ff3;
    rx_state_t       r_rx_state;
    logic [CW-1:0]   r_rx_baud;
    logic [3:0]      r_rx_bits;
    logic [7:0]      r_rx_shift;
    logic [7:0]      r_rx_data;
    logic            r_rx_rdy;
    logic            w_start;

    logic            r_tx_busy;
    logic [9:0]      r_tx_shift;
    logic [CW-1:0]   r_tx_baud;
    logic [3:0]      r_tx_bits;
    logic            r_tx_done;

    assign w_start = r_rx_ff3 & ~r_rx_ff2;

    // Nine samples (start + 8 data) pass through an 8-bit shifter, so the
    // start bit falls off the end and the register holds exactly the data byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_ff1   <= 1'b1;
            r_rx_ff2   <= 1'b1;
            r_rx_ff3   <= 1'b1;
            r_rx_state <= RX_IDLE;
            r_rx_baud  <= '0;
            r_rx_bits  <= '0;
            r_rx_shift <= '0;
            r_rx_data  <= '0;
            r_rx_rdy   <= 1'b0;
        end else begin
            r_rx_ff1 <= RX;
            r_rx_ff2 <= r_rx_ff1;
            r_rx_ff3 <= r_rx_ff2;
            if (clr_rx_rdy)
                r_rx_rdy <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    if (w_start) begin
                        r_rx_state <= RX_RECV;
                        r_rx_baud  <= HALF_LOAD;
                        r_rx_bits  <= '0;
                        r_rx_rdy   <= 1'b0;
                    end
                end
                RX_RECV: begin
                    if (r_rx_baud == '0) begin
                        r_rx_shift <= {r_rx_ff2, r_rx_shift[7:1]};
                        r_rx_bits  <= r_rx_bits + 4'd1;
                        r_rx_baud  <= FULL_LOAD;
                        if (r_rx_bits == 4'd9) begin
                            r_rx_state <= RX_IDLE;
                            r_rx_data  <= r_rx_shift;
                            r_rx_rdy   <= 1'b1;
                        end
                    end else begin
                        r_rx_baud <= r_rx_baud - 1'b1;
                    end
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_busy  <= 1'b0;
            r_tx_shift <= '1;
            r_tx_baud  <= '0;
            r_tx_bits  <= '0;
            r_tx_done  <= 1'b0;
        end else if (!r_tx_busy) begin
            if (trmt) begin
                r_tx_shift <= tx_frame(tx_data);
                r_tx_busy  <= 1'b1;
                r_tx_baud  <= FULL_LOAD;
                r_tx_bits  <= '0;
                r_tx_done  <= 1'b0;
            end
        end else if (r_tx_baud == '0) begin
            if (r_tx_bits == 4'd9) begin
                r_tx_busy <= 1'b0;
                r_tx_done <= 1'b1;
            end else begin
                r_tx_shift <= {1'b1, r_tx_shift[9:1]};
                r_tx_bits  <= r_tx_bits + 4'd1;
                r_tx_baud  <= FULL_LOAD;
            end
        end else begin
            r_tx_baud <= r_tx_baud - 1'b1;
        end
    end

    assign TX      = r_tx_shift[0];
    assign rx_rdy  = r_rx_rdy;
    assign rx_data = r_rx_data;
    assign tx_done = r_tx_done;

endmodule

// File: rtl/uart_wrapper.sv
// RemoteComm responder: pairs received UART bytes (high first) into 16-bit
// commands for cmd_proc and forwards response bytes out over TX.
module uart_wrapper
    import knight_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    uart_wrapper_if.slave   bus
);

    logic        w_rx_rdy;
    logic [7:0]  w_rx_data;
    logic        w_clr_rx_rdy;

    asm_state_t  r_state;
    logic [7:0]  r_high_byte;
    logic [15:0] r_cmd;
    logic        r_cmd_rdy;

    // Every received byte is consumed in the cycle it appears, in either state.
    assign w_clr_rx_rdy = w_rx_rdy;

    uart #(
        .BAUD_DIV(BAUD_DIV)
    ) u_uart (
        .clk        (clk),
        .rst_n      (rst_n),
        .RX         (bus.RX),
        .TX         (bus.TX),
        .rx_rdy     (w_rx_rdy),
        .clr_rx_rdy (w_clr_rx_rdy),
        .rx_data    (w_rx_data),
        .trmt       (bus.trmt),
        .tx_data    (bus.resp),
        .tx_done    (bus.tx_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= HIGH;
            r_high_byte <= '0;
            r_cmd       <= '0;
            r_cmd_rdy   <= 1'b0;
        end else begin
            case (r_state)
                HIGH: begin
                    if (w_rx_rdy) begin
                        r_high_byte <= w_rx_data;
                        r_cmd_rdy   <= 1'b0;
                        r_state     <= LOW;
                    end else if (bus.clr_cmd_rdy) begin
                        r_cmd_rdy <= 1'b0;
                    end
                end
                LOW: begin
                    // Setting takes priority over a coincident clr_cmd_rdy.
                    if (w_rx_rdy) begin
                        r_cmd     <= {r_high_byte, w_rx_data};
                        r_cmd_rdy <= 1'b1;
                        r_state   <= HIGH;
                    end else if (bus.clr_cmd_rdy) begin
                        r_cmd_rdy <= 1'b0;
                    end
                end
                default: r_state <= HIGH;
            endcase
        end
    end

    assign bus.cmd     = r_cmd;
    assign bus.cmd_rdy = r_cmd_rdy;

endmodule

// File: tb/tb_uart_wrapper.sv
// Directed + randomized bench for uart_wrapper with a byte-level command model.
module tb_uart_wrapper;
    import knight_pkg::*;

    localparam int BD = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    uart_wrapper_if bus();

    uart_wrapper #(.BAUD_DIV(BD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: host-visible command state, byte granularity
    logic        m_have_high;
    logic [7:0]  m_high;
    logic [15:0] m_cmd;
    logic        m_rdy;

    task automatic model_reset();
        m_have_high = 1'b0;
        m_high      = 8'h00;
        m_cmd       = 16'h0000;
        m_rdy       = 1'b0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (!m_have_high) begin
            m_have_high = 1'b1;
            m_high      = b;
            m_rdy       = 1'b0;
        end else begin
            m_have_high = 1'b0;
            m_cmd       = {m_high, b};
            m_rdy       = 1'b1;
        end
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_cmd(input string tag);
        check({tag, "_cmd"}, bus.cmd, m_cmd);
        check({tag, "_rdy"}, {15'b0, bus.cmd_rdy}, {15'b0, m_rdy});
        $display("cmd check %s: cmd=%h cmd_rdy=%b", tag, bus.cmd, bus.cmd_rdy);
    endtask

    // Host sends one frame; optionally holds clr_cmd_rdy until cmd_rdy is seen high
    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input logic hold_clr);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        bus.clr_cmd_rdy = hold_clr;
        for (int k = 0; k < 10; k++) begin
            bus.RX = fr[k];
            repeat (BD) begin
                @(negedge clk);
                if (hold_clr && bus.cmd_rdy === 1'b1)
                    bus.clr_cmd_rdy = 1'b0;
            end
        end
        bus.RX = 1'b1;
        bus.clr_cmd_rdy = 1'b0;
        repeat (BD) @(negedge clk);
        model_byte(b);
        $display("host sent byte %h (stop=%b)", b, stop_bit);
    endtask

    task automatic pulse_clr();
        bus.clr_cmd_rdy = 1'b1;
        @(negedge clk);
        bus.clr_cmd_rdy = 1'b0;
        m_rdy = 1'b0;
        @(negedge clk);
    endtask

    // Starts a transmission and checks every bit mid-cell plus exact tx_done timing
    task automatic tx_check(input logic [7:0] r, input string tag);
        logic [9:0] exp_bits;
        logic [9:0] obs_bits;
        exp_bits[0] = 1'b0;
        for (int k = 1; k <= 8; k++) exp_bits[k] = r[k-1];
        exp_bits[9] = 1'b1;
        bus.resp = r;
        bus.trmt = 1'b1;
        @(negedge clk);
        bus.trmt = 1'b0;
        repeat (BD / 2) @(negedge clk);
        obs_bits[0] = bus.TX;
        for (int k = 1; k < 10; k++) begin
            repeat (BD) @(negedge clk);
            obs_bits[k] = bus.TX;
        end
        check({tag, "_bits"}, {6'b0, obs_bits}, {6'b0, exp_bits});
        repeat (BD / 2 - 1) @(negedge clk);
        check({tag, "_done_early"}, {15'b0, bus.tx_done}, 16'h0000);
        @(negedge clk);
        check({tag, "_done"}, {15'b0, bus.tx_done}, 16'h0001);
        $display("tx %s: resp=%h bits=%b tx_done=%b", tag, r, obs_bits, bus.tx_done);
    endtask

    initial begin
        logic       saw_rdy;
        logic [7:0] b1, b2;
        logic       s1, s2;

        bus.RX = 1'b1;
        bus.trmt = 1'b0;
        bus.clr_cmd_rdy = 1'b0;
        bus.resp = 8'h00;
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_tx", {15'b0, bus.TX}, 16'h0001);
        check("rst_tx_done", {15'b0, bus.tx_done}, 16'h0000);
        check_cmd("rst");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // CAL_GYRO, with cmd_rdy watched across the whole first byte
        saw_rdy = 1'b0;
        fork
            send_byte(CAL_GYRO[15:8], 1'b1, 1'b0);
            repeat (11 * BD - 1) begin
                @(negedge clk);
                saw_rdy |= bus.cmd_rdy;
            end
        join
        check("first_byte_rdy_low", {15'b0, saw_rdy}, 16'h0000);
        check_cmd("cal_hi");
        send_byte(CAL_GYRO[7:0], 1'b1, 1'b0);
        check_cmd("cal");

        // cmd_rdy persists without clr, then drops when the next high byte lands
        send_byte(8'h4B, 1'b1, 1'b0);
        check_cmd("4b");
        send_byte(8'hF1, 1'b1, 1'b0);
        repeat (40) @(negedge clk);
        check_cmd("4bf1_hold");
        send_byte(8'h57, 1'b1, 1'b0);
        check_cmd("57_hi");
        send_byte(8'hF2, 1'b1, 1'b0);
        check_cmd("57f2");

        pulse_clr();
        check_cmd("clr");
        pulse_clr();
        check_cmd("clr_idle");

        tx_check(POS_ACK, "ack");
        repeat (5) @(negedge clk);
        check("ack_done_hold", {15'b0, bus.tx_done}, 16'h0001);
        check("ack_tx_idle", {15'b0, bus.TX}, 16'h0001);

        // Full duplex, with a stray trmt in the middle of the outgoing frame
        fork
            tx_check(POS_ACK, "duplex");
            begin
                send_byte(8'h4B, 1'b1, 1'b0);
                send_byte(8'hF1, 1'b1, 1'b0);
            end
            begin
                repeat (3 * BD) @(negedge clk);
                bus.resp = 8'h3C;
                bus.trmt = 1'b1;
                @(negedge clk);
                bus.trmt = 1'b0;
            end
        join
        check_cmd("duplex");

        // clr_cmd_rdy held through the second byte, so it coincides with the set
        send_byte({MOVE_FANFARE, 4'h4}, 1'b1, 1'b0);
        check_cmd("sim_hi");
        send_byte(EAST, 1'b1, 1'b1);
        check_cmd("sim_set");

        // Zero stop bits are still accepted
        send_byte(WEST, 1'b0, 1'b0);
        send_byte(SOUTH, 1'b0, 1'b0);
        check_cmd("stop0");

        // Reset after a lone high byte and mid-transmission
        send_byte(8'h20, 1'b1, 1'b0);
        bus.resp = 8'h5A;
        bus.trmt = 1'b1;
        @(negedge clk);
        bus.trmt = 1'b0;
        repeat (3 * BD + 3) @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        check("midrst_tx", {15'b0, bus.TX}, 16'h0001);
        check("midrst_done", {15'b0, bus.tx_done}, 16'h0000);
        check_cmd("midrst");
        repeat (3) @(negedge clk);
        check("midrst_tx2", {15'b0, bus.TX}, 16'h0001);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        send_byte(8'h20, 1'b1, 1'b0);
        check_cmd("post_rst_hi");
        send_byte(8'h00, 1'b1, 1'b0);
        check_cmd("post_rst");

        // Randomized commands with random clr and stop bits
        for (int i = 0; i < 6; i++) begin
            b1 = 8'($urandom);
            b2 = 8'($urandom);
            s1 = 1'($urandom_range(0, 1));
            s2 = 1'($urandom_range(0, 1));
            send_byte(b1, s1, 1'b0);
            check_cmd("rnd_hi");
            send_byte(b2, s2, 1'b0);
            check_cmd("rnd");
            if ($urandom_range(0, 1) == 1) begin
                pulse_clr();
                check_cmd("rnd_clr");
            end
        end
        b1 = 8'($urandom);
        tx_check(b1, "rnd_tx");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
